operand_loader: RTL
===================

# operand_loader

Upstream feeder for the three-operand adder pipeline (10-bit in1/in2/in3 → 12-bit sum, 2-cycle latency, registers its inputs on every clk edge). Accepts a serial stream of 10-bit words over a valid/ready handshake and groups them into ordered triples. It presents each triple as registered operands with a one-cycle `op_valid` strobe. A delay line produces `res_valid`, which marks the exact cycle the adder's 12-bit result is valid.

## Interface
- `W`, 10, operand width; must match adder operand width
- `LAT`, 2, adder latency in cycles; length of the `res_valid` delay line (≥1)
- `CNTW`, 16, width of the issued-triple counter
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `s_data`  in  W  input word
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  loader accepts a word this cycle
- `hold`  in  1  downstream stall; blocks acceptance
- `flush`  in  1  discard any partial triple
- `in1`, `in2`, `in3`  out  W each  registered operands to adder
- `op_valid`  out  1  one-cycle strobe: `in1`..`in3` hold a new triple
- `res_valid`  out  1  adder output valid this cycle (`op_valid` delayed `LAT` cycles)
- `partial`  out  1  one or two words of a triple are buffered
- `triple_cnt`  out  CNTW  count of issued triples, wraps

## Operation
- Handshake: a word transfers on a rising edge where `s_valid && s_ready`. `s_ready = ~hold & ~flush`, purely combinational from those inputs.
- FSM states:
  - `S0`: no words buffered.
  - `S1`: word A buffered.
  - `S2`: words A and B buffered.
- FSM transitions:
  - `S0`→`S1` on transfer; store A.
  - `S1`→`S2` on transfer; store B.
  - `S2`→`S0` on transfer. At that edge, load `in1`=A, `in2`=B, `in3`=current `s_data`, assert `op_valid`, and increment `triple_cnt`.
  - No transfer: stay in the current state.
- `op_valid` is high for exactly the one cycle following the completing edge. Otherwise it is 0.
- `in1`..`in3` hold their last triple until the next completion. They are never partially updated.
- `flush`, with priority over transfer: on the edge, go to `S0` and drop A/B. It does not affect `in1`..`in3`, `op_valid`, or the delay line already in flight.
- `partial` = state is `S1` or `S2`.
- `triple_cnt` is modulo 2^CNTW; the value 2^CNTW−1 wraps to 0.
- `res_valid` is a `LAT`-stage shift register fed by `op_valid`. It is never gated by `hold` or `flush`, because the adder has no stall.

## Timing
- Reset values: state `S0`; `s_ready` follows inputs; `in1`/`in2`/`in3`=0; `op_valid`=0; `res_valid` (all stages)=0; `partial`=0; `triple_cnt`=0.
- Completing transfer at edge E:
  - `op_valid`=1 in cycle E..E+1.
  - The adder samples the operands at E+1.
  - `res_valid`=1 in cycle E+LAT..E+LAT+1, coincident with the valid adder output.
- Throughput: one word per cycle max, so one triple per 3 cycles. `op_valid` strobes are therefore ≥3 cycles apart.
- `hold` and `flush` are sampled only at edges. `hold` does not age or clear buffered words.
- Reset mid-triple or mid-delay-line: everything clears immediately (asynchronous). Pending `res_valid` pulses are lost.

## Structure
- Shared package holds the FSM state encoding (`S0`/`S1`/`S2`, 2-bit) and the default `W`/`LAT`/`CNTW` constants, so the adder and loader agree on them.
- One natural sub-module: `valid_delay`, a parameterised `LAT`-deep 1-bit shift register with asynchronous reset.
- FSM, operand registers, and counter live in the top module.

## Test plan
- Reset, then words 5, 7, 9 on consecutive cycles:
  - `op_valid` pulses with `in1`=5, `in2`=7, `in3`=9.
  - `res_valid` pulses 2 cycles later.
  - `triple_cnt`=1.
- Words 1023, 1023, 1023 with `hold` high for 3 cycles between the 1st and 2nd word:
  - `s_ready`=0 during `hold`, with no transfer.
  - The triple then issues as 1023/1023/1023, and the adder result aligned with `res_valid` is 3069.
- Words 1, 2, then `flush`, then 3, 4, 6:
  - `partial` goes 1 and then 0 after `flush`.
  - The issued triple is 3/4/6, not 1/2/3.
- Continuous stream of 9 words:
  - Three `op_valid` pulses exactly 3 cycles apart.
  - `res_valid` mirrors them delayed by 2 cycles.
  - `in1`..`in3` are stable between pulses.
- Preload `triple_cnt` to 65535 (via 65535 triples or a forced value), then issue one triple: `triple_cnt`=0.
- Assert `rst_n` low in the cycle after a completing edge: `op_valid`, `res_valid`, and `in1`..`in3` go to 0 immediately, and no `res_valid` pulse appears after release.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared constants for the operand loader and the three-operand adder it feeds.
package operand_loader_pkg;

    // Loader FSM encoding: number of words of the current triple already buffered.
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;

    // Defaults the adder and loader must agree on.
    localparam int unsigned DefW    = 10;
    localparam int unsigned DefLat  = 2;
    localparam int unsigned DefCntw = 16;

    // Width of the adder's sum for three W-bit operands.
    function automatic int unsigned sum_width(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/operand_loader_valid_delay.sv
// LAT-deep 1-bit shift register that tracks the adder's pipeline latency.
module operand_loader_valid_delay #(
    parameter int unsigned LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [LAT-1:0] sr_q, sr_d;

    // Shift the incoming strobe one stage per cycle; stage 0 takes the new input.
    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = d_i;
        for (int i = 1; i < int'(LAT); i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // Delay-line state; the adder never stalls, so there is no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[LAT-1];

endmodule

// File: rtl/operand_loader.sv
// Groups a serial word stream into ordered triples for the three-operand adder
// and flags the cycle in which the adder's result is valid.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned W    = DefW,
    parameter int unsigned LAT  = DefLat,
    parameter int unsigned CNTW = DefCntw
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    s_data_i,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic [W-1:0]    in1_o,
    output logic [W-1:0]    in2_o,
    output logic [W-1:0]    in3_o,
    output logic            op_valid_o,
    output logic            res_valid_o,
    output logic            partial_o,
    output logic [CNTW-1:0] triple_cnt_o
);

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    in1_q, in1_d;
    logic [W-1:0]    in2_q, in2_d;
    logic [W-1:0]    in3_q, in3_d;
    logic            op_valid_q, op_valid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            xfer;

    assign s_ready_o = ~hold_i & ~flush_i;
    assign xfer      = s_valid_i & s_ready_o;

    // Next-state: buffer A and B, then issue all three operands at once on the third word.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        in3_d      = in3_q;
        op_valid_d = 1'b0;
        cnt_d      = cnt_q;
        if (flush_i) begin
            // Drops the partial triple only; issued operands and the delay line are untouched.
            state_d = S0;
        end else if (xfer) begin
            case (state_q)
                S0: begin
                    a_d     = s_data_i;
                    state_d = S1;
                end
                S1: begin
                    b_d     = s_data_i;
                    state_d = S2;
                end
                S2: begin
                    in1_d      = a_q;
                    in2_d      = b_q;
                    in3_d      = s_data_i;
                    op_valid_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = S0;
                end
                default: state_d = S0;
            endcase
        end
    end

    // Loader state, buffered words, issued operands and triple counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S0;
            a_q        <= '0;
            b_q        <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            in3_q      <= '0;
            op_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            in3_q      <= in3_d;
            op_valid_q <= op_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    operand_loader_valid_delay #(
        .LAT (LAT)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (op_valid_q),
        .q_o   (res_valid_o)
    );

    assign in1_o        = in1_q;
    assign in2_o        = in2_q;
    assign in3_o        = in3_q;
    assign op_valid_o   = op_valid_q;
    assign partial_o    = (state_q == S1) || (state_q == S2);
    assign triple_cnt_o = cnt_q;

endmodule
